// File: rtl/stopwatch_ctrl.sv
// Run-control front end for the stopwatch counter core.
// Three raw push-buttons are synchronised, debounced and edge-detected;
// the resulting press pulses drive an IDLE/RUNNING/PAUSED state machine
// whose registered outputs enable counting, strobe a clear, and freeze
// the display for lap readings.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  output logic       run,
  output logic       clear,
  output logic       freeze,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  localparam int NB        = 3;
  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_CLEAR = 2;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    stable;
  logic [NB-1:0]    stable_q;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] cnt [NB];

  state_t state_q;
  state_t next_state;
  logic   next_freeze;
  logic   next_clear;

  assign raw = {clear_btn, stop_btn, start_btn};

  // Two-flop synchroniser per button; nothing downstream sees the raw pins.
  always_ff @(posedge clk) begin
    // NOTE: state elements are written with non-blocking assignments so every
    // flop samples the pre-edge value of its source, independent of statement order.
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a new level is accepted only after DB_CYCLES consecutive
  // samples that differ from the current stable level.
  always_ff @(posedge clk) begin
    // NOTE: the counter array is only three registers, not a RAM, so it is
    // reset with the rest of the logic; a reset mid-count discards the count.
    if (rst) begin
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable_q <= stable;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle pulse on each debounced rising level; releases are ignored.
  assign press = stable & ~stable_q;

  // Next-state and next-output decode, with per-state press priority.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    next_state  = state_q;
    next_freeze = freeze;
    next_clear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        next_freeze = 1'b0;
        if (press[BTN_START]) begin
          next_state = ST_RUNNING;
        end else if (press[BTN_CLEAR]) begin
          next_clear = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (press[BTN_STOP]) begin
          next_state = ST_PAUSED;
        end else if (press[BTN_START]) begin
          next_freeze = ~freeze;
        end
      end
      ST_PAUSED: begin
        if (press[BTN_CLEAR]) begin
          next_state  = ST_IDLE;
          next_freeze = 1'b0;
          next_clear  = 1'b1;
        end else if (press[BTN_START]) begin
          next_state = ST_RUNNING;
        end
      end
      default: begin
        // Unreachable encoding: recover to IDLE with every output low.
        next_state  = ST_IDLE;
        next_freeze = 1'b0;
      end
    endcase
  end

  // State and output registers; run is derived from the next state so it
  // changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      run     <= 1'b0;
      clear   <= 1'b0;
      freeze  <= 1'b0;
    end else begin
      state_q <= next_state;
      run     <= (next_state == ST_RUNNING);
      clear   <= next_clear;
      freeze  <= next_freeze;
    end
  end

  assign state = state_q;

  // Output invariants relied on by the counter core.
  clear_not_while_running: assert property (
    @(posedge clk) disable iff (rst) !(clear && run));

  clear_single_cycle: assert property (
    @(posedge clk) disable iff (rst) clear |=> !clear);

  state_never_bad: assert property (
    @(posedge clk) disable iff (rst) state_q != ST_BAD);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DB_CYCLES=8.
// A behavioural model tracks the expected outputs every cycle; directed
// scenarios add hand-computed literal checks, then random button activity.
module tb_stopwatch_ctrl;

  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       stop_btn  = 1'b0;
  logic       clear_btn = 1'b0;
  logic       run;
  logic       clear;
  logic       freeze;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int clear_seen = 0;

  stopwatch_ctrl #(.DB_CYCLES(DB), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .clear_btn (clear_btn),
    .run       (run),
    .clear     (clear),
    .freeze    (freeze),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 paused. Each button is modelled as a two-sample
  // delay line feeding a "how many consecutive edges has it disagreed" count.
  int       m_mode;
  bit       m_run, m_clr, m_frz;
  bit [2:0] m_s1, m_s2, m_stab, m_prev;
  int       m_diff [3];
  bit       model_ok = 1'b0;

  task automatic model_step();
    bit [2:0] raw;
    bit [2:0] pr;
    raw = {clear_btn, stop_btn, start_btn};
    if (rst) begin
      m_mode = 0; m_run = 0; m_clr = 0; m_frz = 0;
      m_s1 = 0; m_s2 = 0; m_stab = 0; m_prev = 0;
      for (int i = 0; i < 3; i++) m_diff[i] = 0;
      model_ok = 1'b1;
      return;
    end
    pr    = m_stab & ~m_prev;
    m_clr = 0;
    if (m_mode == 0) begin
      if (pr[0]) m_mode = 1;
      else if (pr[2]) m_clr = 1;
    end else if (m_mode == 1) begin
      if (pr[1]) m_mode = 2;
      else if (pr[0]) m_frz = !m_frz;
    end else begin
      if (pr[2]) begin m_mode = 0; m_frz = 0; m_clr = 1; end
      else if (pr[0]) m_mode = 1;
    end
    m_run  = (m_mode == 1);
    m_prev = m_stab;
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_stab[i]) begin
        m_diff[i]++;
        if (m_diff[i] == DB) begin
          m_stab[i] = m_s2[i];
          m_diff[i] = 0;
        end
      end else begin
        m_diff[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: checks all outputs on the falling edge every cycle.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("cmp_state",  32'(state),  32'(m_mode));
      check("cmp_run",    32'(run),    32'(m_run));
      check("cmp_clear",  32'(clear),  32'(m_clr));
      check("cmp_freeze", 32'(freeze), 32'(m_frz));
      if (clear === 1'b1) clear_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs always change 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int mask, input int hold);
    bit [2:0] m;
    m = mask[2:0];
    {clear_btn, stop_btn, start_btn} = m;
    step(hold);
    {clear_btn, stop_btn, start_btn} = 3'b000;
    step(14);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    int seen, same, c0, steady;

    // ---- reset state ----
    step(3);
    check("reset_state",  32'(state),  0);
    check("reset_run",    32'(run),    0);
    check("reset_clear",  32'(clear),  0);
    check("reset_freeze", 32'(freeze), 0);

    // ---- 1: start held from edge 0, run rises at edge 10 ----
    rst = 1'b0;
    start_btn = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step(1);
      if (k < 10) check($sformatf("t1_run_e%0d", k), 32'(run), 0);
      else begin
        check("t1_run_e10",   32'(run),   1);
        check("t1_state_e10", 32'(state), 1);
      end
    end
    steady = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (state != 2'b01 || run != 1'b1) steady++;
    end
    check("t1_held_no_change", 32'(steady), 0);
    start_btn = 1'b0;
    step(14);

    // ---- 2: short glitches are rejected ----
    do_reset();
    press(1, 3);
    check("t2_pulse3_state", 32'(state), 0);
    check("t2_pulse3_run",   32'(run),   0);
    press(1, 7);
    check("t2_pulse7_state", 32'(state), 0);
    check("t2_pulse7_run",   32'(run),   0);
    press(1, 12);
    check("t2_pulse12_state", 32'(state), 1);

    // ---- 3: stop then clear ----
    press(2, 12);
    check("t3_stop_state", 32'(state), 2);
    check("t3_stop_run",   32'(run),   0);
    clear_btn = 1'b1;
    seen = 0;
    same = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (k == 11) clear_btn = 1'b0;
      if (clear) begin
        seen++;
        if (state == 2'b00 && freeze == 1'b0 && run == 1'b0) same++;
      end
    end
    check("t3_clear_pulses",    32'(seen),   1);
    check("t3_clear_with_idle", 32'(same),   1);
    check("t3_idle_state",      32'(state),  0);

    // ---- 4: lap toggling ----
    press(1, 12);
    check("t4_run",     32'(run),    1);
    check("t4_frz0",    32'(freeze), 0);
    press(1, 12);
    check("t4_frz1",    32'(freeze), 1);
    check("t4_run1",    32'(run),    1);
    press(1, 12);
    check("t4_frz2",    32'(freeze), 0);
    check("t4_run2",    32'(run),    1);
    press(1, 12);
    press(2, 12);
    check("t4_paused",       32'(state),  2);
    check("t4_paused_frz",   32'(freeze), 1);
    press(4, 12);
    check("t4_idle",         32'(state),  0);
    check("t4_idle_frz",     32'(freeze), 0);

    // ---- 5: simultaneous presses ----
    press(1, 12);
    press(1, 12);
    check("t5_pre_frz", 32'(freeze), 1);
    press(3, 12);
    check("t5_startstop_state", 32'(state),  2);
    check("t5_startstop_frz",   32'(freeze), 1);
    c0 = clear_seen;
    press(5, 12);
    check("t5_paused_sc_state", 32'(state), 0);
    check("t5_paused_sc_clear", 32'(clear_seen - c0), 1);
    c0 = clear_seen;
    press(5, 12);
    check("t5_idle_sc_state", 32'(state), 1);
    check("t5_idle_sc_clear", 32'(clear_seen - c0), 0);

    // ---- 6: reset mid-debounce ----
    press(1, 12);
    check("t6_pre_frz", 32'(freeze), 1);
    start_btn = 1'b1;
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_rst_state",  32'(state),  0);
    check("t6_rst_run",    32'(run),    0);
    check("t6_rst_clear",  32'(clear),  0);
    check("t6_rst_freeze", 32'(freeze), 0);
    for (int k = 0; k <= 10; k++) begin
      step(1);
      check($sformatf("t6_redebounce_e%0d", k), 32'(run), (k == 10) ? 1 : 0);
    end
    start_btn = 1'b0;
    step(14);

    // ---- random activity against the model ----
    for (int it = 0; it < 60; it++) begin
      int m, h, g;
      bit [2:0] mb;
      m = $urandom_range(0, 7);
      h = $urandom_range(1, 16);
      g = $urandom_range(0, 20);
      mb = m[2:0];
      if ($urandom_range(0, 19) == 0) do_reset();
      {clear_btn, stop_btn, start_btn} = mb;
      step(h);
      {clear_btn, stop_btn, start_btn} = 3'b000;
      step(g);
    end
    step(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Input conditioning and run-control stage that sits directly upstream of the stopwatch counter core. It synchronises and debounces three raw push-buttons (start, stop, clear) and runs an IDLE/RUNNING/PAUSED state machine. From that it drives the counter's run enable, a one-cycle clear strobe, and a display-freeze (lap) flag consumed by the BCD/display path.

Parameters:
DB_CYCLES, 16, consecutive stable cycles required before a debounced button level changes; legal range 2..2^CNT_W-1.
CNT_W, 20, width of each per-button debounce counter.

Ports:
clk  input  1  single system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start_btn  input  1  raw start button, asynchronous, active-high.
stop_btn  input  1  raw stop button, asynchronous, active-high.
clear_btn  input  1  raw clear button, asynchronous, active-high.
run  output  1  registered counter enable; high only in RUNNING.
clear  output  1  registered one-cycle strobe; zeroes sec/min in the counter core.
freeze  output  1  registered lap flag; display holds its last value while high, and counting continues.
state  output  2  registered FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED; 11 is never driven.

Behaviour:
- Reset, sampled at a clk edge while rst=1: state=IDLE, run=0, clear=0, freeze=0. All synchronisers, debounced levels, edge-detect history and debounce counters are zeroed. A debounce in progress is discarded.
- Synchroniser: each button passes through 2 flops (s1, s2) before any other logic.
- Debounce, per button, each edge:
  - if s2==stable, cnt<=0;
  - else if cnt==DB_CYCLES-1, stable<=s2 and cnt<=0;
  - else cnt<=cnt+1.
  - Any glitch shorter than DB_CYCLES cycles leaves stable unchanged.
- Press detect: press = stable & ~stable_q, where stable_q is stable delayed by 1 cycle. It is high for exactly 1 cycle per debounced rising level. Release is ignored, and a held button produces one press only.
- Latency: with a raw input held high before edge 0, stable rises at edge DB_CYCLES+1, the press is visible during the following cycle, and state/run/clear/freeze update at edge DB_CYCLES+2.
- FSM transitions. Evaluated on the press pulses; the listed priority applies when several presses land in the same cycle:
  - IDLE: start -> RUNNING. clear -> stay IDLE and pulse clear. stop is ignored. If start and clear coincide, start wins and no clear pulse is generated.
  - RUNNING: stop -> PAUSED, and freeze is held unchanged. start without stop -> stay RUNNING and toggle freeze. clear is ignored. stop has priority over start.
  - PAUSED: clear -> IDLE, with freeze<=0 and clear pulsed in the same edge. start without clear -> RUNNING, freeze unchanged. stop is ignored. clear has priority over start.
- Outputs:
  - run is registered and equals (next state==RUNNING).
  - clear is high for exactly 1 cycle per accepted clear press; it is never high for 2 consecutive cycles and never high while run=1.
  - freeze is forced to 0 on entry to IDLE.
- The state encoding 11 is unreachable. If it is ever reached, the next edge forces IDLE with all outputs 0.
- The debounce counter never exceeds DB_CYCLES-1, so there is no wrap.

Test Plan (DB_CYCLES=8):
1. Reset, then hold start_btn=1 from edge 0 -> run=0 through edge 9, run=1 and state=01 at edge 10. Keep holding for 100 cycles -> no further state change.
2. Start pulses of 3 and 7 cycles on an idle block -> state stays 00, run=0. A 12-cycle pulse -> state=01.
3. RUNNING, then a stop press -> state=10, run=0. Then a clear press -> state=00, clear=1 for exactly one cycle at the same edge, freeze=0.
4. RUNNING, then start press, start press again -> freeze goes 1 then 0, and run stays 1 throughout. A start press, stop press, then clear press -> freeze ends at 0 in IDLE.
5. Simultaneous presses:
   - start+stop debounced in the same cycle while RUNNING -> state=10, freeze unchanged.
   - start+clear while PAUSED -> state=00 with a clear pulse.
   - start+clear in IDLE -> state=01 with no clear pulse.
6. Assert rst for one cycle mid-debounce (counter=5) while RUNNING with freeze=1 -> the next cycle shows state=00 and all outputs 0. A still-held button then needs a full 8 stable cycles again before it registers.
